// File: rtl/decode_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : decode_warp_scheduler
// Description : Per-warp instruction bundle FIFOs with a round-robin picker
//               driving a registered bundle output into Decode.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_warp_scheduler #(
    parameter int NUM_WARP     = 8,
    parameter int NUM_WARP_LOG = 3,
    parameter int PKT_W        = 64,
    parameter int DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetchValid_i,
    input  logic [NUM_WARP_LOG-1:0] fetchWarp_i,
    input  logic                    fetchPacket0Valid_i,
    input  logic [PKT_W-1:0]        fetchPacket0_i,
    input  logic                    fetchPacket1Valid_i,
    input  logic [PKT_W-1:0]        fetchPacket1_i,
    output logic [NUM_WARP-1:0]     warpFull_o,
    input  logic [NUM_WARP-1:0]     warpActive_i,
    input  logic                    flushValid_i,
    input  logic [NUM_WARP_LOG-1:0] flushWarp_i,
    input  logic                    decodeStall_i,
    output logic [NUM_WARP_LOG-1:0] instWarp_o,
    output logic                    instPacket0Valid_o,
    output logic [PKT_W-1:0]        instPacket0_o,
    output logic                    instPacket1Valid_o,
    output logic [PKT_W-1:0]        instPacket1_o,
    output logic                    overflow_o
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 2 * PKT_W + 2;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [NUM_WARP_LOG-1:0] c_PTR_RESET = NUM_WARP_LOG'(NUM_WARP - 1);

    logic [c_CNT_W-1:0]      r_count [NUM_WARP];
    logic [c_PTR_W-1:0]      r_rdPtr [NUM_WARP];
    logic [c_PTR_W-1:0]      r_wrPtr [NUM_WARP];
    logic [c_ENT_W-1:0]      w_head  [NUM_WARP];
    logic [NUM_WARP_LOG-1:0] r_rrPtr;

    logic                    w_outValid;
    logic                    w_load;
    logic                    w_pushReq;
    logic                    w_pop;
    logic                    w_grantFound;
    logic                    w_overflowSet;
    logic [NUM_WARP_LOG-1:0] w_grantWarp;
    logic [NUM_WARP_LOG-1:0] w_scanIdx;
    logic [NUM_WARP-1:0]     w_flushHit;
    logic [NUM_WARP-1:0]     w_eligible;
    logic [NUM_WARP-1:0]     w_pushOk;
    logic [NUM_WARP-1:0]     w_popHere;

    assign w_outValid = instPacket0Valid_o | instPacket1Valid_o;
    assign w_load     = !w_outValid || !decodeStall_i;
    assign w_pushReq  = fetchValid_i && (fetchPacket0Valid_i || fetchPacket1Valid_i);
    assign w_pop      = w_load && w_grantFound;
    // Fullness is judged on the count at cycle start, so a same-cycle pop cannot rescue the write.
    assign w_overflowSet = w_pushReq && !w_flushHit[fetchWarp_i]
                           && (r_count[fetchWarp_i] == c_DEPTH);

    always_comb begin
        w_flushHit = '0;
        w_eligible = '0;
        w_pushOk   = '0;
        w_popHere  = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            w_flushHit[w] = flushValid_i && (flushWarp_i == NUM_WARP_LOG'(w));
            w_eligible[w] = (r_count[w] != '0) && warpActive_i[w] && !w_flushHit[w];
            w_pushOk[w]   = w_pushReq && (fetchWarp_i == NUM_WARP_LOG'(w))
                            && !w_flushHit[w] && (r_count[w] != c_DEPTH);
            w_popHere[w]  = w_pop && (w_grantWarp == NUM_WARP_LOG'(w));
        end
    end

    // Scan starts just after the last grant; the final step wraps back onto it.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantWarp  = r_rrPtr;
        w_scanIdx    = r_rrPtr;
        for (int i = 1; i <= NUM_WARP; i++) begin
            w_scanIdx = r_rrPtr + NUM_WARP_LOG'(i);
            if (!w_grantFound && w_eligible[w_scanIdx]) begin
                w_grantFound = 1'b1;
                w_grantWarp  = w_scanIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARP; w++) begin
            if (reset || w_flushHit[w]) begin
                r_count[w] <= '0;
                r_rdPtr[w] <= '0;
                r_wrPtr[w] <= '0;
            end else begin
                if (w_pushOk[w]) begin
                    r_wrPtr[w] <= r_wrPtr[w] + c_PTR_ONE;
                end
                if (w_popHere[w]) begin
                    r_rdPtr[w] <= r_rdPtr[w] + c_PTR_ONE;
                end
                if (w_pushOk[w] && !w_popHere[w]) begin
                    r_count[w] <= r_count[w] + c_CNT_ONE;
                end else if (!w_pushOk[w] && w_popHere[w]) begin
                    r_count[w] <= r_count[w] - c_CNT_ONE;
                end
            end
        end
    end

    genvar gw;
    generate
        for (gw = 0; gw < NUM_WARP; gw++) begin : g_warp
            logic [c_ENT_W-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (w_pushOk[gw]) begin
                    r_mem[r_wrPtr[gw]] <= {fetchPacket1Valid_i, fetchPacket1_i,
                                           fetchPacket0Valid_i, fetchPacket0_i};
                end
            end

            assign w_head[gw]     = r_mem[r_rdPtr[gw]];
            assign warpFull_o[gw] = (r_count[gw] == c_DEPTH);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            instWarp_o         <= '0;
            instPacket0Valid_o <= 1'b0;
            instPacket0_o      <= '0;
            instPacket1Valid_o <= 1'b0;
            instPacket1_o      <= '0;
            overflow_o         <= 1'b0;
            r_rrPtr            <= c_PTR_RESET;
        end else begin
            if (w_load) begin
                if (w_grantFound) begin
                    instWarp_o <= w_grantWarp;
                    {instPacket1Valid_o, instPacket1_o,
                     instPacket0Valid_o, instPacket0_o} <= w_head[w_grantWarp];
                    r_rrPtr    <= w_grantWarp;
                end else begin
                    instPacket0Valid_o <= 1'b0;
                    instPacket1Valid_o <= 1'b0;
                end
            end else if (flushValid_i && (flushWarp_i == instWarp_o)) begin
                // A held bundle of a redirected warp is cancelled even while stalled.
                instPacket0Valid_o <= 1'b0;
                instPacket1Valid_o <= 1'b0;
            end
            if (w_overflowSet) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
